bcd_cmd_counter: RTL and testbench
==================================

Name: bcd_cmd_counter

Overview:
- Parametrised DIGITS-digit BCD up/down counter driven by debounced button pulses and UART ASCII commands.
- Supports run/stop, clear, and up/down mode control, plus a multi-digit decimal load command and an ASCII status report returned over a tx byte handshake.
- Sits between the uart rx/tx pair and the FND controller; replaces the fixed 0..9999 counter control unit and datapath pair.

Parameters:
- DIGITS, 4, number of BCD digits; count range is 0 .. 10^DIGITS-1.
- TICK_DIV, 10_000_000, clk cycles per count step (10 Hz at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- btn_run  in  1  one-cycle pulse: toggle run
- btn_clear  in  1  one-cycle pulse: clear
- btn_mode  in  1  one-cycle pulse: toggle direction
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- tx_ready  in  1  uart tx can accept a byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- count_bcd  out  4*DIGITS  counter value, digit 0 in bits [3:0]
- running  out  1  counter enabled
- dir_down  out  1  0 = up, 1 = down
- wrap  out  1  one-cycle pulse on wrap-around
- cmd_err  out  1  one-cycle pulse on a rejected command byte

Behaviour:
- Reset (rst=0, async): count_bcd=0, running=0, dir_down=0, prescaler=0, both FSMs IDLE, tx_valid=0, tx_data=0, wrap=0, cmd_err=0.
- Prescaler:
  - Increments only while running=1 and holds when stopped.
  - At TICK_DIV-1 it asserts an internal tick and returns to 0.
  - Cleared by a clear event.
- Count step on tick:
  - Up: BCD increment with carry chain. 99..9 goes to 0 and pulses wrap.
  - Down: BCD decrement. 0 goes to 99..9 and pulses wrap.
  - wrap is registered and appears the cycle after the step.
- Command decode of rx_data when rx_valid=1 (letters are case-insensitive):
  - 'R': toggle run.
  - 'C': clear.
  - 'M': toggle direction.
  - 'U': set dir_down=0.
  - 'D': set dir_down=1.
  - 'L': enter load.
  - 'S': request report.
  - CR, LF and space in IDLE: ignored silently.
  - Any other byte: cmd_err.
- Button and UART events of the same kind in the same cycle OR together into one event (single toggle, not two).
- Same-cycle priority on count_bcd: clear > load commit > tick. A tick coinciding with clear or load is dropped. Clear sets count=0 and leaves running and dir_down unchanged.
- Load FSM: IDLE -> LOAD(idx = DIGITS-1 .. 0).
  - Each rx byte '0'-'9' shifts into a shadow register, MSD first.
  - After the DIGITS-th digit, shadow is committed to count_bcd in the following cycle, the prescaler is cleared, and the FSM returns to IDLE.
  - A non-digit byte in LOAD: abort, cmd_err pulse, count unchanged, return to IDLE. The aborting byte is not decoded as a command.
  - The counter keeps counting during LOAD.
  - Button pulses remain effective during LOAD.
- Report FSM: IDLE -> SEND(DIGITS digit bytes, MSD first, ASCII '0'+digit) -> CR (0x0D) -> LF (0x0A) -> IDLE.
  - count_bcd is snapshotted the cycle 'S' is accepted; counting continues.
  - tx_valid rises the cycle after acceptance.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - A transfer occurs on tx_valid & tx_ready; the next byte is presented in the following cycle (tx_valid may stay high).
  - tx_valid drops after the LF transfer.
- Report and load interaction:
  - 'S' while a report is busy: cmd_err, ignored.
  - 'S' while in LOAD: the load is aborted as a non-digit byte.
  - 'L' while a report is busy: accepted; the load and report FSMs are independent.
- Reset mid-report or mid-load: everything returns to reset values immediately. No partial commit; no further tx bytes.

Decomposition:
- Package bcd_cmd_pkg holds:
  - ASCII constants (CH_R, CH_C, CH_M, CH_U, CH_D, CH_L, CH_S, CH_CR, CH_LF, CH_SP, CH_0).
  - Load-FSM state enum.
  - Report-FSM state enum.
- Sub-module bcd_digit: one 4-bit BCD digit with inc/dec, carry/borrow in/out, and sync clear/load. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset then 'R' with TICK_DIV=4 -> count_bcd goes 0000, 0001, ... stepping every 4 clk; running=1.
- Load to 9998, up, run: after 2 ticks -> 9999 then 0000 with a wrap pulse. Then 'D' -> next tick gives 9999 with a wrap pulse.
- rx "L0427" -> count_bcd=0x0427 one cycle after the last digit. rx "L04x" -> cmd_err on 'x', count unchanged.
- count=0315, rx 'S', tx_ready held low 5 cycles then high -> tx bytes "0","3","1","5",0x0D,0x0A. tx_data stable while stalled; exactly 6 handshakes.
- btn_run and rx 'r' in the same cycle -> running toggles once. btn_clear coinciding with a tick -> count=0000 and no wrap.
- Assert rst during the second report byte -> tx_valid=0 immediately; after release no further bytes are sent and count=0000.

Source files
------------

// File: rtl/bcd_cmd_pkg.sv
// Shared constants and FSM state types for the BCD command counter.
package bcd_cmd_pkg;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_U  = 8'h55;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;

  typedef enum logic {
    LD_IDLE,
    LD_LOAD
  } load_state_e;

  typedef enum logic [1:0] {
    RP_IDLE,
    RP_SEND,
    RP_CR,
    RP_LF
  } rep_state_e;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= 8'h39);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: synchronous clear/load, step up or down with carry/borrow out.
module bcd_digit
  import bcd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       step_i,
  input  logic       down_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (ld_i) begin
      digit_d = ld_val_i;
    end else if (step_i) begin
      if (down_i) digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
      else        digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Carry/borrow ripples combinationally; the next digit steps in the same edge.
  assign carry_o = step_i & (down_i ? (digit_q == 4'd0) : (digit_q == 4'd9));
  assign digit_o = digit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit_q <= '0;
    else      digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_cmd_counter.sv
// DIGITS-digit BCD up/down counter controlled by button pulses and UART ASCII
// commands, with a multi-digit decimal load and an ASCII status report on tx.
module bcd_cmd_counter
  import bcd_cmd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_run,
  input  logic                  btn_clear,
  input  logic                  btn_mode,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  running,
  output logic                  dir_down,
  output logic                  wrap,
  output logic                  cmd_err
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [IW-1:0] IDX_MSD   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

  logic [7:0]          ch;
  logic [4*DIGITS-1:0] count;
  logic [DIGITS:0]     step_chain;

  logic u_run, u_clear, u_mode, u_up, u_down, ld_start, rp_req, err_d;
  logic clear_ev, tick, tick_eff;

  logic                running_q, running_d, dir_q, dir_d, wrap_q, err_q;
  logic [CW-1:0]       presc_q, presc_d;
  load_state_e         ld_state_q, ld_state_d;
  logic [IW-1:0]       ld_idx_q, ld_idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                commit_q, commit_d;
  rep_state_e          rp_state_q, rp_state_d;
  logic [IW-1:0]       rp_idx_q, rp_idx_d, rp_nxt;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [3:0]          nxt_dig;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  assign ch = to_upper(rx_data);

  // Bytes arriving during LOAD are digits or an abort, never commands.
  always_comb begin
    u_run    = 1'b0;
    u_clear  = 1'b0;
    u_mode   = 1'b0;
    u_up     = 1'b0;
    u_down   = 1'b0;
    ld_start = 1'b0;
    rp_req   = 1'b0;
    err_d    = 1'b0;
    if (rx_valid) begin
      if (ld_state_q == LD_LOAD) begin
        err_d = !is_digit(ch);
      end else begin
        case (ch)
          CH_R:                u_run    = 1'b1;
          CH_C:                u_clear  = 1'b1;
          CH_M:                u_mode   = 1'b1;
          CH_U:                u_up     = 1'b1;
          CH_D:                u_down   = 1'b1;
          CH_L:                ld_start = 1'b1;
          CH_S: begin
            if (rp_state_q == RP_IDLE) rp_req = 1'b1;
            else                       err_d  = 1'b1;
          end
          CH_CR, CH_LF, CH_SP: ;
          default:             err_d    = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    clear_ev  = btn_clear | u_clear;
    running_d = running_q ^ (btn_run | u_run);
    dir_d     = dir_q;
    if (u_up)                       dir_d = 1'b0;
    else if (u_down)                dir_d = 1'b1;
    else if (btn_mode | u_mode)     dir_d = ~dir_q;
    tick    = running_q && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (clear_ev || commit_q) presc_d = '0;
    else if (tick)            presc_d = '0;
    else if (running_q)       presc_d = presc_q + 1'b1;
    tick_eff = tick & ~clear_ev & ~commit_q;
  end

  always_comb begin
    ld_state_d = ld_state_q;
    ld_idx_d   = ld_idx_q;
    shadow_d   = shadow_q;
    commit_d   = 1'b0;
    if (ld_state_q == LD_IDLE) begin
      if (ld_start) begin
        ld_state_d = LD_LOAD;
        ld_idx_d   = IDX_MSD;
      end
    end else if (rx_valid) begin
      if (is_digit(ch)) begin
        shadow_d      = shadow_q << 4;
        shadow_d[3:0] = ch[3:0];
        if (ld_idx_q == '0) begin
          commit_d   = 1'b1;
          ld_state_d = LD_IDLE;
        end else begin
          ld_idx_d = ld_idx_q - 1'b1;
        end
      end else begin
        ld_state_d = LD_IDLE;
      end
    end
  end

  assign rp_nxt = rp_idx_q - 1'b1;

  always_comb begin
    nxt_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IW'(i) == rp_nxt) nxt_dig = snap_q[4*i +: 4];
    end
  end

  always_comb begin
    rp_state_d = rp_state_q;
    rp_idx_d   = rp_idx_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (rp_state_q)
      RP_IDLE: begin
        if (rp_req) begin
          snap_d     = count;
          rp_idx_d   = IDX_MSD;
          tx_valid_d = 1'b1;
          tx_data_d  = CH_0 | {4'h0, count[4*DIGITS-1 -: 4]};
          rp_state_d = RP_SEND;
        end
      end
      RP_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (rp_idx_q == '0) begin
            rp_state_d = RP_CR;
            tx_data_d  = CH_CR;
          end else begin
            rp_idx_d  = rp_nxt;
            tx_data_d = CH_0 | {4'h0, nxt_dig};
          end
        end
      end
      RP_CR: begin
        if (tx_valid_q && tx_ready) begin
          rp_state_d = RP_LF;
          tx_data_d  = CH_LF;
        end
      end
      RP_LF: begin
        if (tx_valid_q && tx_ready) begin
          rp_state_d = RP_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: rp_state_d = RP_IDLE;
    endcase
  end

  assign step_chain[0] = tick_eff;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clear_ev),
      .ld_i     (commit_q),
      .ld_val_i (shadow_q[4*g +: 4]),
      .step_i   (step_chain[g]),
      .down_i   (dir_q),
      .digit_o  (count[4*g +: 4]),
      .carry_o  (step_chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q  <= 1'b0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      presc_q    <= '0;
      ld_state_q <= LD_IDLE;
      ld_idx_q   <= '0;
      shadow_q   <= '0;
      commit_q   <= 1'b0;
      rp_state_q <= RP_IDLE;
      rp_idx_q   <= '0;
      snap_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      running_q  <= running_d;
      dir_q      <= dir_d;
      wrap_q     <= step_chain[DIGITS];
      err_q      <= err_d;
      presc_q    <= presc_d;
      ld_state_q <= ld_state_d;
      ld_idx_q   <= ld_idx_d;
      shadow_q   <= shadow_d;
      commit_q   <= commit_d;
      rp_state_q <= rp_state_d;
      rp_idx_q   <= rp_idx_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign count_bcd = count;
  assign running   = running_q;
  assign dir_down  = dir_q;
  assign wrap      = wrap_q;
  assign cmd_err   = err_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_bcd_cmd_counter.sv
// Directed bench for bcd_cmd_counter: counting, wrap, load, report stream, reset.
module tb_bcd_cmd_counter;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] count_bcd;
  logic        running, dir_down, wrap, cmd_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  bcd_cmd_counter #(.DIGITS(DIGITS), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .count_bcd(count_bcd), .running(running), .dir_down(dir_down),
    .wrap(wrap), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [15:0] model;
    int hs, cyc, extra;

    step(3);
    chk("rst_count", count_bcd, 0);
    chk("rst_running", running, 0);
    chk("rst_dir", dir_down, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_err", cmd_err, 0);
    rst = 1'b1;
    step(1);

    send("R");
    chk("run_on", running, 1);
    step(3);
    chk("cnt_hold", count_bcd, 16'h0000);
    step(1);
    chk("cnt_1", count_bcd, 16'h0001);
    step(4);
    chk("cnt_2", count_bcd, 16'h0002);

    btn_run = 1'b1;
    send("r");
    btn_run = 1'b0;
    chk("run_single_toggle", running, 0);
    step(8);
    chk("stopped_hold", count_bcd, 16'h0002);

    send_str("L9998");
    chk("load_pre_commit", count_bcd, 16'h0002);
    step(1);
    chk("load_9998", count_bcd, 16'h9998);
    send("U");
    send("R");
    step(4);
    chk("up_9999", count_bcd, 16'h9999);
    chk("up_9999_nowrap", wrap, 0);
    step(4);
    chk("up_wrap_cnt", count_bcd, 16'h0000);
    chk("up_wrap_pulse", wrap, 1);
    step(1);
    chk("wrap_one_cycle", wrap, 0);
    send("D");
    chk("dir_down", dir_down, 1);
    step(2);
    chk("down_wrap_cnt", count_bcd, 16'h9999);
    chk("down_wrap_pulse", wrap, 1);
    send("R");
    chk("run_off", running, 0);

    send_str("L0427");
    step(1);
    chk("load_0427", count_bcd, 16'h0427);
    send_str("L04");
    send("x");
    chk("abort_err", cmd_err, 1);
    step(1);
    chk("abort_err_pulse", cmd_err, 0);
    chk("abort_count", count_bcd, 16'h0427);

    send_str("L0315");
    step(1);
    chk("load_0315", count_bcd, 16'h0315);

    model = 16'h0315;
    for (int i = DIGITS - 1; i >= 0; i--) exp_q.push_back(8'h30 + {4'h0, model[4*i +: 4]});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    tx_ready = 1'b0;
    send("S");
    chk("rep_valid", tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", tx_data, exp_q[0]);
      chk("stall_valid", tx_valid, 1);
      if (i == 2) begin
        send("S");
        chk("s_busy_err", cmd_err, 1);
      end else begin
        step(1);
      end
    end
    tx_ready = 1'b1;
    hs  = 0;
    cyc = 0;
    while (hs < 6 && cyc < 40) begin
      if (tx_valid && tx_ready) begin
        chk("tx_byte", tx_data, exp_q.pop_front());
        hs++;
      end
      step(1);
      cyc++;
    end
    chk("handshakes", hs, 6);
    chk("rep_done_valid", tx_valid, 0);
    chk("rep_queue_empty", exp_q.size(), 0);

    send("R");
    step(3);
    btn_clear = 1'b1;
    step(1);
    btn_clear = 1'b0;
    chk("clr_tick_cnt", count_bcd, 16'h0000);
    chk("clr_tick_wrap", wrap, 0);
    chk("clr_keeps_run", running, 1);
    chk("clr_keeps_dir", dir_down, 1);
    step(1);
    chk("clr_no_late_step", count_bcd, 16'h0000);
    chk("clr_no_late_wrap", wrap, 0);

    send("S");
    chk("rep2_valid", tx_valid, 1);
    chk("rep2_byte0", tx_data, 8'h30);
    step(1);
    chk("rep2_byte1_valid", tx_valid, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_txv", tx_valid, 0);
    chk("rst_async_cnt", count_bcd, 16'h0000);
    chk("rst_async_run", running, 0);
    step(2);
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tx_valid) extra++;
    end
    chk("no_tx_after_rst", extra, 0);
    chk("post_rst_count", count_bcd, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
